// File: rtl/move_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : move_scheduler_if
// Brief    : Host/datapath bundle for the move scheduler: segment write
//            port, control inputs, issued-segment outputs and status.
//            MOVE_SCHED_PAUSE_EN adds the pause input.
// Revision : 1.0 - initial release
// ============================================================================
interface move_scheduler_if #(
  parameter int MOVE_BUFFER_BITS = 2,
  parameter int DUR_W            = 64,
  parameter int INC_W            = 64,
  parameter int DIV_W            = 24
);
  logic                      wr_valid;
  logic                      wr_ready;
  logic [DUR_W-1:0]          wr_duration;
  logic [INC_W-1:0]          wr_increment;
  logic [INC_W-1:0]          wr_incinc;
  logic                      wr_dir;
  logic [DIV_W-1:0]          clock_divisor;
  logic                      enable;
  logic                      abort;
`ifdef MOVE_SCHED_PAUSE_EN
  logic                      pause;
`endif
  logic                      seg_load;
  logic [INC_W-1:0]          seg_increment;
  logic [INC_W-1:0]          seg_incinc;
  logic                      seg_dir;
  logic                      tick;
  logic                      busy;
  logic [MOVE_BUFFER_BITS:0] level;
  logic [7:0]                moves_completed;

`ifdef MOVE_SCHED_PAUSE_EN
  modport master (
    output wr_valid, wr_duration, wr_increment, wr_incinc, wr_dir,
           clock_divisor, enable, abort, pause,
    input  wr_ready, seg_load, seg_increment, seg_incinc, seg_dir,
           tick, busy, level, moves_completed
  );
  modport slave (
    input  wr_valid, wr_duration, wr_increment, wr_incinc, wr_dir,
           clock_divisor, enable, abort, pause,
    output wr_ready, seg_load, seg_increment, seg_incinc, seg_dir,
           tick, busy, level, moves_completed
  );
`else
  modport master (
    output wr_valid, wr_duration, wr_increment, wr_incinc, wr_dir,
           clock_divisor, enable, abort,
    input  wr_ready, seg_load, seg_increment, seg_incinc, seg_dir,
           tick, busy, level, moves_completed
  );
  modport slave (
    input  wr_valid, wr_duration, wr_increment, wr_incinc, wr_dir,
           clock_divisor, enable, abort,
    output wr_ready, seg_load, seg_increment, seg_incinc, seg_dir,
           tick, busy, level, moves_completed
  );
`endif
endinterface
`default_nettype wire

// File: rtl/move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : move_scheduler
// Brief    : Ring-buffered segment queue feeding the step datapath. Pops one
//            segment at a time, strobes seg_load for one cycle, then emits
//            divided tick strobes until the segment duration is used up.
//            Optional feature macro: MOVE_SCHED_PAUSE_EN (adds pause input).
// Revision : 1.0 - initial release
// ============================================================================
module move_scheduler #(
  parameter int MOVE_BUFFER_BITS = 2,
  parameter int DUR_W            = 64,
  parameter int INC_W            = 64,
  parameter int DIV_W            = 24
) (
  input  wire logic       CLK,
  input  wire logic       resetn,
  move_scheduler_if.slave bus
);

  localparam int               c_DEPTH   = 1 << MOVE_BUFFER_BITS;
  localparam int               c_PTR_W   = MOVE_BUFFER_BITS + 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
  localparam logic [DUR_W-1:0] c_DUR_ONE = 1;
  localparam logic [DIV_W-1:0] c_DIV_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DUR_W-1:0]     rem_q, rem_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [INC_W-1:0]     seg_inc_q, seg_inc_d;
  logic [INC_W-1:0]     seg_incinc_q, seg_incinc_d;
  logic                 seg_dir_q, seg_dir_d;
  logic [7:0]           moves_q, moves_d;

  logic [DUR_W-1:0]     mem_dur_q    [c_DEPTH];
  logic [INC_W-1:0]     mem_inc_q    [c_DEPTH];
  logic [INC_W-1:0]     mem_incinc_q [c_DEPTH];
  logic                 mem_dir_q    [c_DEPTH];

  logic [MOVE_BUFFER_BITS-1:0] w_wr_idx, w_rd_idx;
  logic                 w_full, w_empty, w_push, w_tick, w_count_en;
  logic                 w_head_zero;
  logic [DIV_W-1:0]     w_div_m1;

  assign w_wr_idx    = wr_ptr_q[MOVE_BUFFER_BITS-1:0];
  assign w_rd_idx    = rd_ptr_q[MOVE_BUFFER_BITS-1:0];
  assign w_empty     = (wr_ptr_q == rd_ptr_q);
  assign w_full      = (wr_ptr_q[MOVE_BUFFER_BITS] != rd_ptr_q[MOVE_BUFFER_BITS]) &&
                       (w_wr_idx == w_rd_idx);
  assign w_head_zero = (mem_dur_q[w_rd_idx] == '0);
  // A zero divisor behaves as one tick per cycle.
  assign w_div_m1    = (bus.clock_divisor == '0) ? '0 : bus.clock_divisor - c_DIV_ONE;
  // Abort discards any write presented in the same cycle.
  assign w_push      = bus.wr_valid && !w_full && !bus.abort;

`ifdef MOVE_SCHED_PAUSE_EN
  assign w_count_en  = !bus.pause;
`else
  assign w_count_en  = 1'b1;
`endif

  // Next-state, pointer and segment bookkeeping; defaults hold every register.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rem_d        = rem_q;
    div_cnt_d    = div_cnt_q;
    seg_inc_d    = seg_inc_q;
    seg_incinc_d = seg_incinc_q;
    seg_dir_d    = seg_dir_q;
    moves_d      = moves_q;
    w_tick       = 1'b0;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    end

    if (bus.abort) begin
      // Flush: read pointer catches up with the (unchanged) write pointer.
      state_d  = ST_IDLE;
      rd_ptr_d = wr_ptr_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.enable && !w_empty) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            if (w_head_zero) begin
              moves_d = moves_q + 8'd1;
            end else begin
              seg_inc_d    = mem_inc_q[w_rd_idx];
              seg_incinc_d = mem_incinc_q[w_rd_idx];
              seg_dir_d    = mem_dir_q[w_rd_idx];
              rem_d        = mem_dur_q[w_rd_idx];
              state_d      = ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          div_cnt_d = '0;
          state_d   = ST_RUN;
        end
        ST_RUN: begin
          if (w_count_en) begin
            // >= rather than == so a divisor lowered mid-run still fires.
            if (div_cnt_q >= w_div_m1) begin
              w_tick    = 1'b1;
              div_cnt_d = '0;
              rem_d     = rem_q - c_DUR_ONE;
              if (rem_q == c_DUR_ONE) begin
                moves_d = moves_q + 8'd1;
                // Chain straight into the next segment; a zero-length head
                // is left for IDLE to retire.
                if (bus.enable && !w_empty && !w_head_zero) begin
                  rd_ptr_d     = rd_ptr_q + c_PTR_ONE;
                  seg_inc_d    = mem_inc_q[w_rd_idx];
                  seg_incinc_d = mem_incinc_q[w_rd_idx];
                  seg_dir_d    = mem_dir_q[w_rd_idx];
                  rem_d        = mem_dur_q[w_rd_idx];
                  state_d      = ST_LOAD;
                end else begin
                  state_d = ST_IDLE;
                end
              end
            end else begin
              div_cnt_d = div_cnt_q + c_DIV_ONE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register and control/datapath registers with async active-low reset.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rem_q        <= '0;
      div_cnt_q    <= '0;
      seg_inc_q    <= '0;
      seg_incinc_q <= '0;
      seg_dir_q    <= 1'b0;
      moves_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rem_q        <= rem_d;
      div_cnt_q    <= div_cnt_d;
      seg_inc_q    <= seg_inc_d;
      seg_incinc_q <= seg_incinc_d;
      seg_dir_q    <= seg_dir_d;
      moves_q      <= moves_d;
    end
  end

  // Queue storage; contents are qualified by the pointers so no reset needed.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      mem_dur_q[w_wr_idx]    <= bus.wr_duration;
      mem_inc_q[w_wr_idx]    <= bus.wr_increment;
      mem_incinc_q[w_wr_idx] <= bus.wr_incinc;
      mem_dir_q[w_wr_idx]    <= bus.wr_dir;
    end
  end

  assign bus.wr_ready        = !w_full;
  assign bus.seg_load        = (state_q == ST_LOAD);
  assign bus.seg_increment   = seg_inc_q;
  assign bus.seg_incinc      = seg_incinc_q;
  assign bus.seg_dir         = seg_dir_q;
  assign bus.tick            = w_tick;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.level           = wr_ptr_q - rd_ptr_q;
  assign bus.moves_completed = moves_q;

endmodule
`default_nettype wire

// File: tb/tb_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_scheduler
// Brief    : Self-checking bench for move_scheduler. A negedge monitor logs
//            seg_load and tick events; a timeline model predicts them from
//            the queued segments and the divisor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_scheduler;
  localparam int MBB = 2, DUR_W = 64, INC_W = 64, DIV_W = 24;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  move_scheduler_if #(.MOVE_BUFFER_BITS(MBB), .DUR_W(DUR_W), .INC_W(INC_W), .DIV_W(DIV_W)) bus_if ();

  move_scheduler #(.MOVE_BUFFER_BITS(MBB), .DUR_W(DUR_W), .INC_W(INC_W), .DIV_W(DIV_W)) dut (
    .CLK    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  typedef struct { logic [DUR_W-1:0] dur; logic [INC_W-1:0] inc; logic [INC_W-1:0] incinc; logic dir; } seg_t;
  typedef struct { int unsigned cyc; logic [INC_W-1:0] inc; logic [INC_W-1:0] incinc; logic dir; } load_t;

  load_t       loads[$];
  int unsigned ticks[$];
  seg_t        pushed[$];
  load_t       exp_loads[$];
  int unsigned exp_ticks[$];
  int unsigned cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  // Event monitor: samples away from the active edge.
  always @(negedge clk) begin
    load_t l;
    if (bus_if.seg_load === 1'b1) begin
      l.cyc = cyc; l.inc = bus_if.seg_increment; l.incinc = bus_if.seg_incinc; l.dir = bus_if.seg_dir;
      loads.push_back(l);
    end
    if (bus_if.tick === 1'b1) ticks.push_back(cyc);
    cyc++;
  end

  task automatic clear_log();
    loads.delete(); ticks.delete(); pushed.delete();
  endtask

  // Queue model: an entry is kept only while fewer than the depth are pending.
  task automatic push(input logic [DUR_W-1:0] dur, input logic [INC_W-1:0] inc,
                      input logic [INC_W-1:0] incinc, input logic dir);
    seg_t s;
    @(posedge clk); #1;
    bus_if.wr_valid = 1'b1; bus_if.wr_duration = dur; bus_if.wr_increment = inc;
    bus_if.wr_incinc = incinc; bus_if.wr_dir = dir;
    s.dur = dur; s.inc = inc; s.incinc = incinc; s.dir = dir;
    if (pushed.size() < (1 << MBB)) pushed.push_back(s);
    @(posedge clk); #1;
    bus_if.wr_valid = 1'b0;
  endtask

  task automatic go(output int unsigned e);
    @(posedge clk); #1;
    bus_if.enable = 1'b1;
    e = cyc;
  endtask

  task automatic stop();
    @(posedge clk); #1;
    bus_if.enable = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (bus_if.busy === 1'b0 && bus_if.level === '0) begin ok = 1'b1; break; end
    end
  endtask

  // Timeline model: the head is popped the cycle after enable; zero-length
  // heads retire one per cycle; each real segment loads, ticks every
  // max(div,1) cycles for dur ticks, and the next loads one cycle later.
  task automatic model_timeline(input int unsigned e, input int unsigned div);
    int unsigned t, d, n;
    load_t el;
    d = (div == 0) ? 1 : div;
    t = e + 1;
    exp_loads.delete(); exp_ticks.delete();
    foreach (pushed[i]) begin
      n = int'(pushed[i].dur);
      if (n == 0) begin t++; continue; end
      el.cyc = t; el.inc = pushed[i].inc; el.incinc = pushed[i].incinc; el.dir = pushed[i].dir;
      exp_loads.push_back(el);
      for (int k = 1; k <= int'(n); k++) exp_ticks.push_back(t + d * k);
      t = t + d * n + 1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus_if.busy !== 1'b0 || bus_if.tick !== 1'b0 || bus_if.seg_load !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ctrl: busy=%b tick=%b load=%b required 0 0 0", bus_if.busy, bus_if.tick, bus_if.seg_load);
    end
    tests_run++;
    if (bus_if.level !== 3'd0 || bus_if.wr_ready !== 1'b1 || bus_if.moves_completed !== 8'd0) begin
      tests_failed++; $display("FAIL reset_status: level=%0d wr_ready=%b moves=%0d required 0 1 0", bus_if.level, bus_if.wr_ready, bus_if.moves_completed);
    end
    tests_run++;
    if (bus_if.seg_increment !== '0 || bus_if.seg_incinc !== '0 || bus_if.seg_dir !== 1'b0) begin
      tests_failed++; $display("FAIL reset_seg: inc=%h incinc=%h dir=%b required 0", bus_if.seg_increment, bus_if.seg_incinc, bus_if.seg_dir);
    end
  endtask

  task automatic test_single();
    int unsigned e; bit ok;
    clear_log();
    bus_if.clock_divisor = 24'd4;
    push(64'd3, 64'd5, -64'sd1, 1'b1);
    go(e);
    wait_done(200, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL single_timeout: busy=%b level=%0d required idle", bus_if.busy, bus_if.level); end
    tests_run++;
    if (loads.size() != 1) begin tests_failed++; $display("FAIL single_load_count: got %0d required 1", loads.size()); end
    else begin
      tests_run++;
      if (loads[0].cyc !== e + 1 || loads[0].inc !== 64'd5 || loads[0].incinc !== 64'hFFFF_FFFF_FFFF_FFFF || loads[0].dir !== 1'b1) begin
        tests_failed++; $display("FAIL single_load: cyc=%0d inc=%h incinc=%h dir=%b required cyc=%0d 5 -1 1", loads[0].cyc, loads[0].inc, loads[0].incinc, loads[0].dir, e + 1);
      end
      tests_run++;
      if (ticks.size() != 3) begin tests_failed++; $display("FAIL single_tick_count: got %0d required 3", ticks.size()); end
      else begin
        for (int k = 0; k < 3; k++) begin
          tests_run++;
          if (ticks[k] !== loads[0].cyc + 4 * (k + 1)) begin
            tests_failed++; $display("FAIL single_tick%0d: offset %0d required %0d", k, ticks[k] - loads[0].cyc, 4 * (k + 1));
          end
        end
      end
    end
    tests_run++;
    if (bus_if.busy !== 1'b0 || bus_if.moves_completed !== 8'd1 || bus_if.level !== 3'd0) begin
      tests_failed++; $display("FAIL single_end: busy=%b moves=%0d level=%0d required 0 1 0", bus_if.busy, bus_if.moves_completed, bus_if.level);
    end
    stop();
  endtask

  task automatic test_full_queue();
    int unsigned e; bit ok; logic [7:0] m0;
    clear_log();
    bus_if.clock_divisor = 24'd2;
    m0 = bus_if.moves_completed;
    for (int i = 0; i < 4; i++) push(64'($urandom_range(1, 3)), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    tests_run++;
    if (bus_if.level !== 3'd4 || bus_if.wr_ready !== 1'b0) begin
      tests_failed++; $display("FAIL full_level: level=%0d wr_ready=%b required 4 0", bus_if.level, bus_if.wr_ready);
    end
    push(64'd7, 64'hDEAD, 64'hBEEF, 1'b0);
    tests_run++;
    if (bus_if.level !== 3'd4) begin tests_failed++; $display("FAIL full_overflow: level=%0d required 4", bus_if.level); end
    go(e);
    wait_done(500, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL full_timeout: busy=%b level=%0d required idle", bus_if.busy, bus_if.level); end
    model_timeline(e, 2);
    tests_run++;
    if (loads.size() != exp_loads.size()) begin tests_failed++; $display("FAIL full_load_count: got %0d required %0d", loads.size(), exp_loads.size()); end
    foreach (exp_loads[i]) if (i < loads.size()) begin
      tests_run++;
      if (loads[i].cyc !== exp_loads[i].cyc || loads[i].inc !== exp_loads[i].inc || loads[i].incinc !== exp_loads[i].incinc || loads[i].dir !== exp_loads[i].dir) begin
        tests_failed++; $display("FAIL full_load%0d: cyc=%0d inc=%h required cyc=%0d inc=%h", i, loads[i].cyc, loads[i].inc, exp_loads[i].cyc, exp_loads[i].inc);
      end
    end
    tests_run++;
    if (ticks.size() != exp_ticks.size()) begin tests_failed++; $display("FAIL full_tick_count: got %0d required %0d", ticks.size(), exp_ticks.size()); end
    foreach (exp_ticks[i]) if (i < ticks.size()) begin
      tests_run++;
      if (ticks[i] !== exp_ticks[i]) begin tests_failed++; $display("FAIL full_tick%0d: cyc=%0d required %0d", i, ticks[i], exp_ticks[i]); end
    end
    tests_run++;
    if (bus_if.moves_completed !== 8'(m0 + 8'd4)) begin
      tests_failed++; $display("FAIL full_moves: got %0d required %0d", bus_if.moves_completed, 8'(m0 + 8'd4));
    end
    stop();
  endtask

  task automatic test_zero_duration();
    int unsigned e; bit ok; logic [7:0] m0;
    clear_log();
    bus_if.clock_divisor = 24'd1;
    m0 = bus_if.moves_completed;
    push(64'd0, 64'd11, 64'd12, 1'b0);
    push(64'd2, 64'd21, 64'd22, 1'b1);
    go(e);
    @(negedge clk); @(negedge clk);
    tests_run++;
    if (bus_if.moves_completed !== 8'(m0 + 8'd1) || loads.size() != 0) begin
      tests_failed++; $display("FAIL zero_drop: moves=%0d loads=%0d required %0d 0", bus_if.moves_completed, loads.size(), 8'(m0 + 8'd1));
    end
    wait_done(100, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL zero_timeout: busy=%b level=%0d required idle", bus_if.busy, bus_if.level); end
    model_timeline(e, 1);
    tests_run++;
    if (loads.size() != 1 || exp_loads.size() != 1) begin tests_failed++; $display("FAIL zero_load_count: got %0d required 1", loads.size()); end
    else begin
      tests_run++;
      if (loads[0].cyc !== exp_loads[0].cyc || loads[0].inc !== 64'd21 || loads[0].dir !== 1'b1) begin
        tests_failed++; $display("FAIL zero_load: cyc=%0d inc=%0d required cyc=%0d inc=21", loads[0].cyc, loads[0].inc, exp_loads[0].cyc);
      end
    end
    tests_run++;
    if (ticks.size() != 2 || ticks[0] !== exp_ticks[0] || ticks[1] !== exp_ticks[1]) begin
      tests_failed++; $display("FAIL zero_ticks: count=%0d first=%0d required 2 ticks from %0d", ticks.size(), (ticks.size() > 0) ? ticks[0] : 0, exp_ticks[0]);
    end
    tests_run++;
    if (bus_if.moves_completed !== 8'(m0 + 8'd2)) begin
      tests_failed++; $display("FAIL zero_moves: got %0d required %0d", bus_if.moves_completed, 8'(m0 + 8'd2));
    end
    stop();
  endtask

  task automatic test_divisor_zero();
    int unsigned e; bit ok;
    clear_log();
    bus_if.clock_divisor = 24'd0;
    push(64'd3, 64'd9, 64'd1, 1'b0);
    go(e);
    wait_done(100, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL div0_timeout: busy=%b level=%0d required idle", bus_if.busy, bus_if.level); end
    model_timeline(e, 0);
    tests_run++;
    if (loads.size() != 1) begin tests_failed++; $display("FAIL div0_load_count: got %0d required 1", loads.size()); end
    tests_run++;
    if (ticks.size() != exp_ticks.size()) begin tests_failed++; $display("FAIL div0_tick_count: got %0d required %0d", ticks.size(), exp_ticks.size()); end
    foreach (exp_ticks[i]) if (i < ticks.size()) begin
      tests_run++;
      if (ticks[i] !== exp_ticks[i]) begin tests_failed++; $display("FAIL div0_tick%0d: cyc=%0d required %0d", i, ticks[i], exp_ticks[i]); end
    end
    stop();
  endtask

  task automatic test_random();
    int unsigned e, div, n; bit ok; logic [7:0] m0;
    for (int r = 0; r < 4; r++) begin
      clear_log();
      div = $urandom_range(1, 4);
      n = $urandom_range(1, 4);
      bus_if.clock_divisor = 24'(div);
      m0 = bus_if.moves_completed;
      for (int i = 0; i < int'(n); i++) push(64'($urandom_range(1, 5)), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      go(e);
      wait_done(1000, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL rand%0d_timeout: busy=%b level=%0d required idle", r, bus_if.busy, bus_if.level); end
      model_timeline(e, div);
      tests_run++;
      if (loads.size() != exp_loads.size()) begin tests_failed++; $display("FAIL rand%0d_load_count: got %0d required %0d", r, loads.size(), exp_loads.size()); end
      foreach (exp_loads[i]) if (i < loads.size()) begin
        tests_run++;
        if (loads[i].cyc !== exp_loads[i].cyc || loads[i].inc !== exp_loads[i].inc || loads[i].incinc !== exp_loads[i].incinc || loads[i].dir !== exp_loads[i].dir) begin
          tests_failed++; $display("FAIL rand%0d_load%0d: cyc=%0d inc=%h required cyc=%0d inc=%h", r, i, loads[i].cyc, loads[i].inc, exp_loads[i].cyc, exp_loads[i].inc);
        end
      end
      tests_run++;
      if (ticks.size() != exp_ticks.size()) begin tests_failed++; $display("FAIL rand%0d_tick_count: got %0d required %0d", r, ticks.size(), exp_ticks.size()); end
      foreach (exp_ticks[i]) if (i < ticks.size()) begin
        tests_run++;
        if (ticks[i] !== exp_ticks[i]) begin tests_failed++; $display("FAIL rand%0d_tick%0d: cyc=%0d required %0d", r, i, ticks[i], exp_ticks[i]); end
      end
      tests_run++;
      if (bus_if.moves_completed !== 8'(m0 + 8'(n))) begin
        tests_failed++; $display("FAIL rand%0d_moves: got %0d required %0d", r, bus_if.moves_completed, 8'(m0 + 8'(n)));
      end
      stop();
    end
  endtask

  task automatic test_abort();
    int unsigned e, nt; bit seen; logic [7:0] m0;
    clear_log();
    bus_if.clock_divisor = 24'd3;
    for (int i = 0; i < 3; i++) push(64'd10, 64'(i + 1), 64'd0, 1'b0);
    go(e);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin @(negedge clk); if (loads.size() > 0) begin seen = 1'b1; break; end end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL abort_no_load: loads=%0d required 1", loads.size()); end
    repeat (4) @(negedge clk);
    tests_run++;
    if (bus_if.level !== 3'd2 || bus_if.busy !== 1'b1) begin
      tests_failed++; $display("FAIL abort_pre: level=%0d busy=%b required 2 1", bus_if.level, bus_if.busy);
    end
    m0 = bus_if.moves_completed;
    @(posedge clk); #1 bus_if.abort = 1'b1;
    nt = ticks.size();
    @(posedge clk); #1 bus_if.abort = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus_if.tick !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.level !== 3'd0) begin
      tests_failed++; $display("FAIL abort_state: tick=%b busy=%b level=%0d required 0 0 0", bus_if.tick, bus_if.busy, bus_if.level);
    end
    tests_run++;
    if (bus_if.moves_completed !== m0) begin tests_failed++; $display("FAIL abort_moves: got %0d required %0d", bus_if.moves_completed, m0); end
    repeat (40) @(negedge clk);
    tests_run++;
    if (loads.size() != 1 || ticks.size() != nt) begin
      tests_failed++; $display("FAIL abort_quiet: loads=%0d ticks=%0d required 1 %0d", loads.size(), ticks.size(), nt);
    end
    stop();
  endtask

  task automatic test_async_reset();
    int unsigned e;
    clear_log();
    bus_if.clock_divisor = 24'd5;
    push(64'd10, 64'd7, 64'd3, 1'b1);
    go(e);
    for (int n = 0; n < 50 && loads.size() == 0; n++) @(negedge clk);
    repeat (2) @(posedge clk);
    @(posedge clk); #2 resetn = 1'b0;
    #1;
    tests_run++;
    if (bus_if.busy !== 1'b0 || bus_if.tick !== 1'b0 || bus_if.seg_load !== 1'b0 || bus_if.level !== 3'd0) begin
      tests_failed++; $display("FAIL areset_ctrl: busy=%b tick=%b load=%b level=%0d required 0 0 0 0", bus_if.busy, bus_if.tick, bus_if.seg_load, bus_if.level);
    end
    tests_run++;
    if (bus_if.moves_completed !== 8'd0 || bus_if.seg_increment !== '0 || bus_if.seg_dir !== 1'b0 || bus_if.wr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL areset_regs: moves=%0d inc=%h dir=%b wr_ready=%b required 0 0 0 1", bus_if.moves_completed, bus_if.seg_increment, bus_if.seg_dir, bus_if.wr_ready);
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    clear_log();
    repeat (30) @(negedge clk);
    tests_run++;
    if (ticks.size() != 0 || loads.size() != 0) begin
      tests_failed++; $display("FAIL areset_quiet: ticks=%0d loads=%0d required 0 0", ticks.size(), loads.size());
    end
    stop();
  endtask

  initial begin
    bus_if.wr_valid = 1'b0; bus_if.wr_duration = '0; bus_if.wr_increment = '0;
    bus_if.wr_incinc = '0; bus_if.wr_dir = 1'b0; bus_if.clock_divisor = 24'd1;
    bus_if.enable = 1'b0; bus_if.abort = 1'b0;
`ifdef MOVE_SCHED_PAUSE_EN
    bus_if.pause = 1'b0;
`endif
    test_reset();
    test_single();
    test_full_queue();
    test_zero_duration();
    test_divisor_zero();
    test_random();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
`default_nettype wire
